// File: rtl/ac1_ctrl_pkg.sv
// Shared types and helpers for the first-level accumulator sequencer.
// Holds the FSM state enum, index-width helpers and the result-width rule.
package ac1_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index width for a count of n, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the activation-serial accumulator result.
    function automatic int ac1_width(input int m, input int pa);
        return $clog2(m) + pa;
    endfunction

endpackage

// File: rtl/ctrl_wrap_cnt.sv
// Modulo-N counter with enable and synchronous active-low clear.
// Ports: clk, clr_n, en in; count, at_end (comb), wrap (registered) out.
module ctrl_wrap_cnt
    import ac1_ctrl_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_end,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // High on the enabled cycle that rolls the count back to zero.
    assign at_end = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= at_end;
            if (at_end) begin
                count <= '0;
            end else if (en) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ac1_ctrl.sv
// Sequencer for the activation-serial accumulator of the SMAC datapath.
// Ports: clk, rst_n, start, in_valid in; busy, w_and_s, cl_en, act_idx,
// w_idx, ac1_valid, ac2_first, ac2_last, done out.
module ac1_ctrl
    import ac1_ctrl_pkg::*;
#(
    parameter int M  = 16,
    parameter int Pa = 8,
    parameter int Pw = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 busy,
    output logic                 w_and_s,
    output logic                 cl_en,
    output logic [idx_w(Pa)-1:0] act_idx,
    output logic [idx_w(Pw)-1:0] w_idx,
    output logic                 ac1_valid,
    output logic                 ac2_first,
    output logic                 ac2_last,
    output logic                 done
);

    localparam int AW    = idx_w(Pa);
    localparam int WW    = idx_w(Pw);
    localparam int RES_W = ac1_width(M, Pa);

    if (Pa < 2 || Pw < 1 || RES_W <= Pa) begin : g_bad_cfg
        $error("ac1_ctrl: need Pa>=2, Pw>=1, M>=2");
    end

    state_t state_q;
    state_t state_d;
    logic   capture;
    logic   act_end;
    logic   op_end;
    logic   act_wrap;
    logic   op_wrap;
    logic   first_q;

    assign capture = (state_q == RUN) && in_valid;

    ctrl_wrap_cnt #(
        .N (Pa),
        .W (AW)
    ) u_act_cnt (
        .clk    (clk),
        .clr_n  (rst_n),
        .en     (capture),
        .count  (act_idx),
        .at_end (act_end),
        .wrap   (act_wrap)
    );

    // Weight plane advances on each activation wrap; its own wrap
    // marks the final capture of the operation.
    ctrl_wrap_cnt #(
        .N (Pw),
        .W (WW)
    ) u_w_cnt (
        .clk    (clk),
        .clr_n  (rst_n),
        .en     (act_end),
        .count  (w_idx),
        .at_end (op_end),
        .wrap   (op_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= act_end && (w_idx == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        w_and_s = 1'b0;
        cl_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                w_and_s = in_valid;
                // First bit of a pass loads rather than accumulates.
                cl_en   = in_valid && (act_idx == '0);
                if (op_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ac1_valid = act_wrap;
    assign ac2_first = first_q;
    assign ac2_last  = op_wrap;
    assign done      = op_wrap;

endmodule

// File: tb/tb_ac1_ctrl.sv
// Self-checking bench for ac1_ctrl (defaults and a Pa=2/Pw=1 instance).
// Table vectors for the stall pass plus directed multi-cycle sequences.
module tb_ac1_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid;
    logic       busy, w_and_s, cl_en;
    logic [2:0] act_idx;
    logic [1:0] w_idx;
    logic       ac1_valid, ac2_first, ac2_last, done;

    logic       start2, iv2;
    logic       busy2, ws2, cl2;
    logic [0:0] act2, w2;
    logic       v2, f2, l2, d2;

    int n_chk  = 0;
    int n_pass = 0;

    ac1_ctrl #(.M(16), .Pa(8), .Pw(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .busy      (busy),
        .w_and_s   (w_and_s),
        .cl_en     (cl_en),
        .act_idx   (act_idx),
        .w_idx     (w_idx),
        .ac1_valid (ac1_valid),
        .ac2_first (ac2_first),
        .ac2_last  (ac2_last),
        .done      (done)
    );

    ac1_ctrl #(.M(4), .Pa(2), .Pw(1)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .in_valid  (iv2),
        .busy      (busy2),
        .w_and_s   (ws2),
        .cl_en     (cl2),
        .act_idx   (act2),
        .w_idx     (w2),
        .ac1_valid (v2),
        .ac2_first (f2),
        .ac2_last  (l2),
        .done      (d2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int iv;
        int e;
    } vec_t;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    function automatic int ep(int b, int ws, int cl, int a, int w,
                              int v, int f, int l, int d);
        return (b << 11) | (ws << 10) | (cl << 9) | (a << 6) | (w << 4)
             | (v << 3) | (f << 2) | (l << 1) | d;
    endfunction

    function automatic int pk();
        int r;
        r = 0;
        r[11:0] = {busy, w_and_s, cl_en, act_idx, w_idx,
                   ac1_valid, ac2_first, ac2_last, done};
        return r;
    endfunction

    function automatic int pk2();
        int r;
        r = 0;
        r[8:0] = {busy2, ws2, cl2, act2, w2, v2, f2, l2, d2};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[14];

    initial begin
        int dcyc, caps, cls, dns, k;
        bit  in_a, act;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        start2 = 1'b0; iv2 = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("reset_state", pk(), 0);
        chk("reset_state2", pk2(), 0);
        tick();
        rst_n = 1'b1;

        // Pa=2, Pw=1: load, one add, then the single pass completes.
        start2 = 1'b1; iv2 = 1'b1;
        @(negedge clk);
        chk("small_c0", pk2(), 0);
        tick(); start2 = 1'b0;
        @(negedge clk);
        chk("small_c1", pk2(), 9'b111_0_0_0000);
        tick();
        @(negedge clk);
        chk("small_c2", pk2(), 9'b110_1_0_0000);
        tick();
        @(negedge clk);
        chk("small_c3", pk2(), 9'b000_0_0_1111);
        tick(); iv2 = 1'b0;

        // First pass with in_valid low in cycles 3..5.
        tbl[0]  = '{1, 1, ep(0,0,0,0,0,0,0,0,0)};
        tbl[1]  = '{0, 1, ep(1,1,1,0,0,0,0,0,0)};
        tbl[2]  = '{0, 1, ep(1,1,0,1,0,0,0,0,0)};
        tbl[3]  = '{0, 0, ep(1,0,0,2,0,0,0,0,0)};
        tbl[4]  = '{0, 0, ep(1,0,0,2,0,0,0,0,0)};
        tbl[5]  = '{0, 0, ep(1,0,0,2,0,0,0,0,0)};
        tbl[6]  = '{0, 1, ep(1,1,0,2,0,0,0,0,0)};
        tbl[7]  = '{0, 1, ep(1,1,0,3,0,0,0,0,0)};
        tbl[8]  = '{0, 1, ep(1,1,0,4,0,0,0,0,0)};
        tbl[9]  = '{0, 1, ep(1,1,0,5,0,0,0,0,0)};
        tbl[10] = '{0, 1, ep(1,1,0,6,0,0,0,0,0)};
        tbl[11] = '{0, 1, ep(1,1,0,7,0,0,0,0,0)};
        tbl[12] = '{0, 1, ep(1,1,1,0,1,1,1,0,0)};
        tbl[13] = '{0, 1, ep(1,1,0,1,1,0,0,0,0)};
        for (int c = 0; c < 14; c++) begin
            start    = tbl[c].st[0];
            in_valid = tbl[c].iv[0];
            @(negedge clk);
            chk($sformatf("stall_c%0d", c), pk(), tbl[c].e);
            tick();
        end
        start = 1'b0; in_valid = 1'b1;
        dcyc = -1;
        for (int c = 14; c < 41; c++) begin
            @(negedge clk);
            if (done && dcyc < 0) dcyc = c;
            tick();
        end
        chk("stall_done_cycle", dcyc, 36);

        // Unstalled run; start at 5 ignored, start in done cycle 33 accepted.
        for (int c = 0; c < 35; c++) begin
            int b, cl, a, w, v;
            start = (c == 0 || c == 5 || c == 33);
            in_valid = 1'b1;
            act = (c >= 1 && c <= 32);
            b  = (act || c == 34) ? 1 : 0;
            cl = (c == 1 || c == 9 || c == 17 || c == 25 || c == 34) ? 1 : 0;
            a  = act ? (c - 1) % 8 : 0;
            w  = act ? (c - 1) / 8 : 0;
            v  = (c == 9 || c == 17 || c == 25 || c == 33) ? 1 : 0;
            @(negedge clk);
            chk($sformatf("run_c%0d", c), pk(),
                ep(b, b, cl, a, w, v, (c == 9) ? 1 : 0,
                   (c == 33) ? 1 : 0, (c == 33) ? 1 : 0));
            tick();
        end
        start = 1'b0;

        // Second run started at 34; reset at its 14th cycle (abs 47).
        for (int c = 35; c < 47; c++) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("pre_reset_act", int'(act_idx), 5);
        chk("pre_reset_w", int'(w_idx), 1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", pk(), 0);
        dns = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) dns++;
            tick();
        end
        chk("post_reset_quiet", dns, 0);

        // Fresh operation after reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        caps = 0; dcyc = -1;
        for (int c = 1; c < 100 && dcyc < 0; c++) begin
            @(negedge clk);
            if (w_and_s) caps++;
            if (done) dcyc = c;
            tick();
        end
        chk("fresh_caps", caps, 32);
        chk("fresh_done_cycle", dcyc, 33);

        // Random stalls over 100 operations.
        for (int op = 0; op < 100; op++) begin
            caps = 0; cls = 0; dns = 0; k = 0;
            start = 1'b1;
            in_valid = 1'($urandom_range(1));
            tick();
            start = 1'b0;
            in_a = 1'b0;
            while (!in_a && k < 400) begin
                in_valid = 1'($urandom_range(1));
                @(negedge clk);
                if (w_and_s) caps++;
                if (cl_en) cls++;
                if (done) begin dns++; in_a = 1'b1; end
                tick();
                k++;
            end
            @(negedge clk);
            if (done) dns++;
            tick();
            chk($sformatf("rnd%0d_caps", op), caps, 32);
            chk($sformatf("rnd%0d_cl", op), cls, 4);
            chk($sformatf("rnd%0d_done", op), dns, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
